// File: rtl/pio_link_host.sv
// pio_link_host: initiator end of the 16-bit PIO change-detect word protocol.
// Streams 2^SIGNAL_SIZE_LOG samples to the device, one per ACK, then collects
// the same number of result words onto the m_* strobe interface.
// Build option: define PIO_SEP_ELIDE_EN to send a separator only between
// equal consecutive words instead of after every sample.
module pio_link_host #(
  parameter int SIGNAL_SIZE_LOG = 7,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [15:0] s_tdata,
  output logic        m_tvalid,
  output logic [15:0] m_tdata,
  output logic [15:0] pio_out,
  input  logic [15:0] pio_in
);
  localparam logic [15:0] SEP   = 16'h8001;
  localparam logic [15:0] ZMARK = 16'h8000;
  localparam int          CW    = SIGNAL_SIZE_LOG + 1;
  localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BLK     = {1'b1, {SIGNAL_SIZE_LOG{1'b0}}};
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // FIN is the extra cycle that turns the last result strobe into the done pulse
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_W, WAIT_S, RECV, FIN} state_t;

  state_t        state, state_n;
  logic [15:0]   pio_n, mdat_n;
  logic          busy_n, done_n, err_n, mvld_n;
  logic [CW-1:0] sent_cnt, sent_n, rcv_cnt, rcv_n;
  logic [TW-1:0] to_cnt, to_n;
`ifdef PIO_SEP_ELIDE_EN
  logic [15:0]   pend, pend_n;
`endif

  logic          ack, word, to_hit;
  logic [15:0]   rm;
  logic [CW-1:0] sent_inc, rcv_inc;

  assign ack      = (pio_in == SEP);
  assign word     = (pio_in != 16'h0000) && !ack;
  assign rm       = (s_tdata == SEP) ? 16'h8002 : s_tdata;
  assign to_hit   = (to_cnt == TO_LAST);
  assign sent_inc = sent_cnt + 1'b1;
  assign rcv_inc  = rcv_cnt + 1'b1;

  // next-state and output decode; every wait state shares the same timeout abort
  always_comb begin
    state_n  = state;
    pio_n    = pio_out;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = err;
    mvld_n   = 1'b0;
    mdat_n   = m_tdata;
    sent_n   = sent_cnt;
    rcv_n    = rcv_cnt;
    to_n     = to_cnt;
    s_tready = 1'b0;
`ifdef PIO_SEP_ELIDE_EN
    pend_n   = pend;
`endif
    case (state)
      IDLE: begin
        // a start landing on the done pulse belongs to the finished block
        if (start && !done) begin
          err_n   = 1'b0;
          busy_n  = 1'b1;
          sent_n  = '0;
          rcv_n   = '0;
          to_n    = '0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        s_tready = 1'b1;
        if (s_tvalid) begin
          to_n = '0;
`ifdef PIO_SEP_ELIDE_EN
          // device only sees changes, so a repeat needs a separator first
          if (rm == pio_out) begin
            pend_n  = rm;
            pio_n   = SEP;
            state_n = WAIT_S;
          end else begin
            pio_n   = rm;
            state_n = WAIT_W;
          end
`else
          pio_n   = rm;
          state_n = WAIT_W;
`endif
        end
      end
      WAIT_W: begin
        if (ack) begin
          to_n   = '0;
          sent_n = sent_inc;
`ifdef PIO_SEP_ELIDE_EN
          state_n = (sent_inc == BLK) ? RECV : LOAD;
`else
          pio_n   = SEP;
          state_n = WAIT_S;
`endif
        end else if (to_hit) begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      WAIT_S: begin
        if (ack) begin
          to_n = '0;
`ifdef PIO_SEP_ELIDE_EN
          pio_n   = pend;
          state_n = WAIT_W;
`else
          state_n = (sent_cnt == BLK) ? RECV : LOAD;
`endif
        end else if (to_hit) begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      RECV: begin
        if (word) begin
          to_n   = '0;
          mvld_n = 1'b1;
          mdat_n = (pio_in == ZMARK) ? 16'h0000 : pio_in;
          rcv_n  = rcv_inc;
          if (rcv_inc == BLK) state_n = FIN;
        end else if (to_hit) begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers; reset parks the link on the separator word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pio_out  <= SEP;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata  <= 16'h0000;
      sent_cnt <= '0;
      rcv_cnt  <= '0;
      to_cnt   <= '0;
`ifdef PIO_SEP_ELIDE_EN
      pend     <= 16'h0000;
`endif
    end else begin
      state    <= state_n;
      pio_out  <= pio_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      m_tvalid <= mvld_n;
      m_tdata  <= mdat_n;
      sent_cnt <= sent_n;
      rcv_cnt  <= rcv_n;
      to_cnt   <= to_n;
`ifdef PIO_SEP_ELIDE_EN
      pend     <= pend_n;
`endif
    end
  end
endmodule

// File: tb/tb_pio_link_host.sv
// Self-checking bench for pio_link_host (SIGNAL_SIZE_LOG=2, TIMEOUT_CYCLES=16).
// A device responder ACKs two cycles after every pio_out change; the expected
// wire sequence is built from the sample list alone.
module tb_pio_link_host;
  localparam int          SSL = 2;
  localparam int          TO  = 16;
  localparam int          NB  = 1 << SSL;
  localparam logic [15:0] SEP = 16'h8001;

  logic        clk, rst_n, start, busy, done, err;
  logic        s_tvalid, s_tready, m_tvalid;
  logic [15:0] s_tdata, m_tdata, pio_out, pio_in;

  pio_link_host #(.SIGNAL_SIZE_LOG(SSL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .pio_out(pio_out), .pio_in(pio_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total, bad, cyc, acks, si;
  logic [1:0]  ackd;
  logic [15:0] last_po, mdl_last;
  bit          resp_on, src_on, track, stray_on;
  logic [15:0] src [NB];
  logic [15:0] obs[$], exp_po[$], expq[$];

  typedef struct packed {
    logic [15:0] pin;
    logic        stb;
    logic [15:0] dat;
  } rv_t;
  rv_t rtab [10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] remap(input logic [15:0] s);
    return (s == SEP) ? 16'h8002 : s;
  endfunction

  // expected sequence of distinct values the device sees on pio_out
  task automatic build_exp();
    logic [15:0] r;
    exp_po.delete();
    for (int i = 0; i < NB; i++) begin
      r = remap(src[i]);
`ifdef PIO_SEP_ELIDE_EN
      if (r == mdl_last) exp_po.push_back(SEP);
      exp_po.push_back(r);
      mdl_last = r;
`else
      exp_po.push_back(r);
      exp_po.push_back(SEP);
      mdl_last = SEP;
`endif
    end
  endtask

  // one clock: observe, run the responder and the source, then drive inputs
  task automatic step();
    logic chg;
    @(posedge clk); #1;
    cyc++;
    chg = (pio_out !== last_po);
    if (chg && track) begin
      obs.push_back(pio_out);
      chk("hold_until_ack", 32'(acks), 32'(obs.size() - 1));
    end
    if (resp_on) begin
      pio_in = ackd[1] ? SEP : 16'h0000;
      if (ackd[1]) acks++;
    end
    ackd    = {ackd[0], chg};
    last_po = pio_out;
    if (src_on && si < NB) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = src[si];
      if (s_tvalid && s_tready) si++;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = 16'($urandom());
    end
    start = stray_on ? ($urandom_range(0, 5) == 0) : 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tdata = 16'h0; pio_in = 16'h0;
    resp_on = 0; src_on = 0; track = 0; stray_on = 0; ackd = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    last_po  = SEP;
    mdl_last = SEP;
  endtask

  task automatic send_phase(input bit stray);
    int n;
    build_exp();
    obs.delete(); acks = 0; ackd = 2'b00; si = 0;
    resp_on = 1; src_on = 1; track = 1;
    start = 1'b1;
    step();
    stray_on = stray;
    n = 0;
    while (!(obs.size() >= exp_po.size() && acks >= obs.size()) && n < 400) begin
      step(); n++;
    end
    chk("send_in_budget", 32'(n < 400), 32'd1);
    stray_on = 0;
    step(); step();
    track = 0;
    chk("pio_seq_len", 32'(obs.size()), 32'(exp_po.size()));
    for (int i = 0; i < exp_po.size() && i < obs.size(); i++)
      chk("pio_seq", 32'(obs[i]), 32'(exp_po[i]));
    chk("accepts", 32'(si), 32'(NB));
    chk("busy_in_recv", 32'(busy), 32'd1);
    chk("tready_in_recv", 32'(s_tready), 32'd0);
    src_on = 0; resp_on = 0; pio_in = 16'h0000;
  endtask

  task automatic rstep();
    step();
    if (m_tvalid) begin
      chk("strobe_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) chk("recv_data", 32'(m_tdata), 32'(expq.pop_front()));
    end
  endtask

  task automatic recv_random();
    logic [15:0] w;
    int gaps;
    expq.delete();
    for (int i = 0; i < NB; i++) begin
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        pio_in = ($urandom_range(0, 1) == 1) ? SEP : 16'h0000;
        rstep();
      end
      case ($urandom_range(0, 3))
        0:       w = 16'h8000;
        1:       w = 16'h8002;
        default: w = 16'($urandom());
      endcase
      if (w == 16'h0000 || w == SEP) w = 16'h1234;
      expq.push_back((w == 16'h8000) ? 16'h0000 : w);
      pio_in = w;
      rstep();
    end
    pio_in = 16'h0000;
    rstep();
    chk("recv_all_words", 32'(expq.size()), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    rstep();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int n, c0;
    total = 0; bad = 0; cyc = 0; acks = 0; si = 0;
    rtab[0] = '{16'h0005, 1'b1, 16'h0005};
    rtab[1] = '{16'h8001, 1'b0, 16'h0000};
    rtab[2] = '{16'h8001, 1'b0, 16'h0000};
    rtab[3] = '{16'h8000, 1'b1, 16'h0000};
    rtab[4] = '{16'h8001, 1'b0, 16'h0000};
    rtab[5] = '{16'h8001, 1'b0, 16'h0000};
    rtab[6] = '{16'h0003, 1'b1, 16'h0003};
    rtab[7] = '{16'h8001, 1'b0, 16'h0000};
    rtab[8] = '{16'h8001, 1'b0, 16'h0000};
    rtab[9] = '{16'h8002, 1'b1, 16'h8002};

    // power-on reset values
    do_reset();
    chk("rst_pio_out", 32'(pio_out), 32'h8001);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_mdata", 32'(m_tdata), 32'd0);

    // directed block with a repeat and the reserved value, then table-driven receive
    src = '{16'h0001, 16'h0001, 16'h0002, 16'h8001};
    send_phase(1'b0);
    for (int i = 0; i < 10; i++) begin
      pio_in = rtab[i].pin;
      step();
      chk("tab_strobe", 32'(m_tvalid), 32'(rtab[i].stb));
      if (rtab[i].stb) chk("tab_data", 32'(m_tdata), 32'(rtab[i].dat));
    end
    pio_in = 16'h0000;
    step();
    chk("tab_done", 32'(done), 32'd1);
    chk("tab_busy_low", 32'(busy), 32'd0);
    // start coincident with done is dropped
    start = 1'b1;
    step();
    chk("start_at_done_busy", 32'(busy), 32'd0);
    chk("start_at_done_tready", 32'(s_tready), 32'd0);
    step();
    chk("start_at_done_tready2", 32'(s_tready), 32'd0);

    // directed block with adjacent equal samples
    src = '{16'h0003, 16'h0004, 16'h0004, 16'h0005};
    send_phase(1'b0);
    recv_random();

    // random blocks with stalls, repeats, reserved values and stray starts
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 3))
          0:       src[i] = (i == 0) ? 16'h8001 : src[(i == 0) ? 0 : i - 1];
          1:       src[i] = 16'h8001;
          default: src[i] = 16'($urandom());
        endcase
      end
      send_phase(1'b1);
      recv_random();
    end

    // asynchronous reset while waiting for an ACK
    do_reset();
    src = '{16'h0042, 16'h0043, 16'h0044, 16'h0045};
    obs.delete(); acks = 0; si = 0; track = 1; src_on = 1; resp_on = 0;
    start = 1'b1;
    step();
    n = 0;
    while (obs.size() == 0 && n < 50) begin step(); n++; end
    chk("reached_wait", 32'(obs.size()), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pio_out", 32'(pio_out), 32'h8001);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tready", 32'(s_tready), 32'd0);
    chk("arst_mvalid", 32'(m_tvalid), 32'd0);
    do_reset();

    // ACK never arrives: abort exactly TO cycles after pio_out changed
    obs.delete(); acks = 0; si = 0; track = 1; src_on = 1; resp_on = 0;
    start = 1'b1;
    step();
    n = 0;
    while (obs.size() == 0 && n < 50) begin step(); n++; end
    c0 = cyc;
    n = 0;
    while (!err && n < 60) begin step(); n++; end
    chk("timeout_latency", 32'(cyc - c0), 32'(TO));
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_pio_held", 32'(pio_out), 32'h0042);
    src_on = 0; track = 0;
    step(); step();
    chk("err_sticky", 32'(err), 32'd1);
    start = 1'b1;
    step();
    chk("start_clears_err", 32'(err), 32'd0);
    chk("start_sets_busy", 32'(busy), 32'd1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pio_link_host.md
Name: pio_link_host

Overview:
- Initiator (HPS-side) end of the 16-bit PIO change-detect word protocol used by the FIR filter wrapper. Implemented in RTL so a soft core, DMA or testbench can drive the filter without the HPS.
- Takes a block of 2^SIGNAL_SIZE_LOG samples from an input stream and writes them one at a time to the device, waiting for each ACK.
- Then collects 2^SIGNAL_SIZE_LOG result words from the device and presents them on an output stream.

Parameters:
- SIGNAL_SIZE_LOG, 7, block length is 2^SIGNAL_SIZE_LOG samples in and results out.
- TIMEOUT_CYCLES, 1024, idle cycles allowed while waiting for an ACK or result word before abort; at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a block when busy=0.
- busy  out  1  high from the accepted start until done or err.
- done  out  1  one-cycle pulse after the last result word.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- s_tvalid  in  1  input sample valid.
- s_tready  out  1  input sample accepted when s_tvalid & s_tready.
- s_tdata  in  16  input sample.
- m_tvalid  out  1  one-cycle result strobe; no backpressure.
- m_tdata  out  16  result word.
- pio_out  out  16  drives device data_in.
- pio_in  in  16  from device data_out; same clock domain, sampled directly.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: pio_out=0x8001; busy=0; done=0; err=0; s_tready=0; m_tvalid=0; m_tdata=0; all counters 0; state IDLE.
- Reset applied mid-block aborts immediately. The device must also be reset before the next block, because it accepts one block per reset.
- IDLE:
  - On start: clear err, busy=1, go LOAD.
  - Start while busy is ignored.
- LOAD:
  - s_tready=1.
  - On accept: sample 0x8001 is remapped to 0x8002, since 0x8001 is reserved as the separator/ACK.
  - Register the sample into pio_out, clear the timeout counter, go WAIT_W.
- WAIT_W:
  - Hold pio_out.
  - When pio_in==0x8001: set pio_out=0x8001 (separator), increment sent count, go WAIT_S.
- WAIT_S:
  - Wait for pio_in==0x8001.
  - If sent count==2^SIGNAL_SIZE_LOG go RECV, else go LOAD.
- ACK timing:
  - The ACK is a single-cycle 0x8001 that appears 2 cycles after pio_out changes.
  - The host must detect this single-cycle value and must not require it to be held.
- RECV:
  - Any cycle with pio_in not equal to 0x0000 and not equal to 0x8001 is a result word.
  - Mapping: 0x8000 produces m_tdata=0x0000; all other values pass through unchanged, including 0x8002.
  - m_tvalid=1 for that cycle, one cycle after pio_in; receive count increments.
  - After the 2^SIGNAL_SIZE_LOG-th word: done=1 for one cycle, busy=0, go IDLE.
- Timeout:
  - In WAIT_W, WAIT_S and RECV, a counter clears on each ACK or result word and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: err=1, busy=0, go IDLE, pio_out held.
  - In RECV the counter starts on entry. It must tolerate the device's post-block latency, so TIMEOUT_CYCLES must exceed the device's pipeline depth.
- LOAD never times out; source stalls are legal.
- Count widths are SIGNAL_SIZE_LOG+1 bits; no wrap occurs inside a block.
- Simultaneous events: a start in the same cycle as done is ignored.

Optional Feature:
- Macro: PIO_SEP_ELIDE_EN.
- Defined:
  - After the WAIT_W ACK, pio_out keeps the sample and the FSM goes straight to LOAD.
  - A separator cycle (0x8001, wait for ACK) is inserted only when the next remapped sample equals the current pio_out. This roughly halves transfer time.
- Not defined: a separator is sent after every sample, as specified above.

Test Plan:
1. Reset: assert rst_n=0 during WAIT_W -> pio_out=0x8001, busy=0, s_tready=0, m_tvalid=0 asynchronously.
2. SIGNAL_SIZE_LOG=2, samples 0x0001,0x0001,0x0002,0x8001, responder ACKs 2 cycles after each change -> pio_out sequence 0001,8001,0001,8001,0002,8001,8002,8001; each held until its ACK; then RECV.
3. RECV with pio_in sequence 0005,8001,8001,8000,8001,8001,0003,8001,8001,8002 -> m_tdata 0x0005,0x0000,0x0003,0x8002; done pulse one cycle after the last strobe; busy=0.
4. TIMEOUT_CYCLES=16, no ACK after the first sample -> err=1 and busy=0 exactly 16 cycles after pio_out changed; pio_out stays at the sample; next start clears err.
5. Start pulsed while busy, and start coincident with done -> both ignored; no extra s_tready.
6. PIO_SEP_ELIDE_EN defined, samples 0x0003,0x0004,0x0004,0x0005 -> pio_out 0003,0004,8001,0004,0005.
